grf_wb_arbiter: RTL
===================

# grf_wb_arbiter

Write-back arbiter for the general register file's single write port. Two producers share that port: requester 0 is the ALU/load path and requester 1 is the multiply/divide unit. Each producer presents a (PC, destination, data) triple through a valid/ready handshake. The block grants one producer per cycle with round-robin fairness, registers the winner into an output stage that drives the register file's WE/A3/WD/PC inputs, and exports a pending-destination mask for decode hazard checks.

## Interface
- INIT_PRIO, default 0: requester favoured first after reset (0 or 1).
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low (0 = reset, sampled at posedge clk).
- r0_valid  in  1  requester 0 has a write to present.
- r0_pc  in  32  PC of the instruction producing r0_wd.
- r0_a3  in  5  destination register for requester 0.
- r0_wd  in  32  write data for requester 0.
- r0_ready  out  1  requester 0 transfer accepted this cycle.
- r1_valid, r1_pc, r1_a3, r1_wd, r1_ready: same as r0_*, for requester 1.
- grf_we  out  1  register-file write enable (registered).
- grf_a3  out  5  register-file write address (registered).
- grf_wd  out  32  register-file write data (registered).
- grf_pc  out  32  PC forwarded to the register file for its write log (registered).
- pend_mask  out  32  bit i = 1 while a write to $i sits in the output stage.
- grant_cnt  out  16  number of accepted transfers since reset; wraps.

## Operation
- A transfer on requester k happens when rk_valid & rk_ready at a posedge.
- rk_ready is combinational from the valid inputs and the priority bit. There is no backpressure from the register file, so at least one requester is always serviceable.
- If exactly one requester is valid, its ready = 1.
- If both are valid, the requester selected by the priority bit `prio` gets ready = 1 and the other gets ready = 0.
- `prio` flips to the other requester only when both were valid and a grant occurred. A single-requester grant leaves `prio` unchanged.
- On a transfer, the output stage loads grf_pc/grf_a3/grf_wd from the winner.
- grf_we <= (a3 != 0) on a transfer, so a write to $0 is accepted and consumes the slot but never writes.
- With no transfer, grf_we <= 0 and the other output fields hold their previous values.
- pend_mask is derived from the output stage: pend_mask = grf_we ? (1 << grf_a3) : 0. Bit 0 is never set.
- grant_cnt increments by 1 per transfer, including transfers to $0. It wraps from 0xFFFF to 0x0000.
- When both requesters target the same register, both writes reach the register file in grant order. The later write wins; no merging or dropping.
- The handshake contract: a requester holds valid and its payload stable until it sees ready. The block does not check this.

## Timing
- Latency: a transfer at edge N makes grf_we/a3/wd/pc valid during cycle N..N+1. The register file commits the write at edge N+1.
- Throughput: one write per cycle sustained.
- With both requesters continuously valid, grants alternate every cycle.
- Reset (reset = 0 at a posedge) sets:
  - grf_we = 0, grf_a3 = 0, grf_wd = 0, grf_pc = 0
  - pend_mask = 0, grant_cnt = 0, prio = INIT_PRIO
- While reset = 0:
  - r0_ready = r1_ready = 0.
  - No transfer occurs, and any write already in the output stage is discarded, i.e. grf_we goes to 0 at that edge.
- On the first cycle with reset = 1, readies are computed normally.
- States: IDLE (grf_we = 0) and WRITE (grf_we = 1).
  - Any transfer to a nonzero register moves the block to WRITE.
  - A transfer to $0, or no transfer, moves it to IDLE.
  - There are no multi-cycle states.

## Test plan
- **Reset:** hold reset = 0 for 2 cycles with both valids high → r0_ready = r1_ready = 0, grf_we = 0, pend_mask = 0, grant_cnt = 0. Release → first grant goes to INIT_PRIO.
- **Single requester:** r0 presents (pc 0x3000, a3 5, wd 0x12345678) for 1 cycle → next cycle grf_we = 1, grf_a3 = 5, grf_wd = 0x12345678, grf_pc = 0x3000, pend_mask = 0x20. The cycle after that, grf_we = 0 and pend_mask = 0.
- **Contention:** both valid for 4 cycles with INIT_PRIO = 0 → grant order r0, r1, r0, r1; each requester sees ready on alternating cycles; grant_cnt = 4.
- **Priority retention:** r1 alone for 3 cycles, then both valid → the first contested grant goes to the requester selected by `prio`, which is unchanged by the uncontested r1 grants.
- **$0 write:** r1 writes a3 = 0, wd = 0xFFFFFFFF → ready = 1, grant_cnt increments, grf_we stays 0, pend_mask = 0.
- **Reset mid-operation:** a transfer at edge N, then reset = 0 at edge N+1 → grf_we = 0 after edge N+1 and the write is dropped. Also load grant_cnt to 0xFFFF via 65535 transfers, then one more → grant_cnt = 0x0000.

Source files
------------

// File: rtl/grf_wb_arbiter.sv
// Write-back arbiter for the GRF single write port.
// Two producers (0: ALU/load, 1: mul/div) compete through valid/ready; the
// winner is registered into an output stage driving the register file's
// WE/A3/WD/PC inputs. Round-robin only advances on contested grants.

// Per-requester ready generation. A requester is ready when the block is out
// of reset, it is valid, and it either holds priority or has no competitor.
module grf_wb_req_port (
  input  logic en,
  input  logic valid,
  input  logic favoured,
  input  logic other_valid,
  output logic ready
);

  // Ready is purely combinational; the register file never backpressures.
  always_comb begin
    ready = en & valid & (favoured | ~other_valid);
  end

endmodule

module grf_wb_arbiter #(
  parameter int INIT_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_valid,
  input  logic [31:0] r0_pc,
  input  logic [4:0]  r0_a3,
  input  logic [31:0] r0_wd,
  output logic        r0_ready,
  input  logic        r1_valid,
  input  logic [31:0] r1_pc,
  input  logic [4:0]  r1_a3,
  input  logic [31:0] r1_wd,
  output logic        r1_ready,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc,
  output logic [31:0] pend_mask,
  output logic [15:0] grant_cnt
);

  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  a3;
    logic [31:0] wd;
  } wb_req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  wb_req_t              req [NUM_REQ];
  logic [NUM_REQ-1:0]   valid;
  logic [NUM_REQ-1:0]   ready;
  wb_req_t              win;
  logic                 xfer;
  logic                 contested;
  logic                 prio;
  state_t               state;

  assign req[0]   = {r0_pc, r0_a3, r0_wd};
  assign req[1]   = {r1_pc, r1_a3, r1_wd};
  assign valid    = {r1_valid, r0_valid};
  assign r0_ready = ready[0];
  assign r1_ready = ready[1];

  // Each port sees the other's valid; prio names which side wins a tie.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_port
    grf_wb_req_port u_port (
      .en          (reset),
      .valid       (valid[k]),
      .favoured    (prio == 1'(k)),
      .other_valid (valid[NUM_REQ-1-k]),
      .ready       (ready[k])
    );
  end

  // At most one ready is high, so ready[1] doubles as the winner index.
  always_comb begin
    xfer      = |ready;
    contested = &valid;
    win       = ready[1] ? req[1] : req[0];
  end

  // Output-stage FSM: WRITE while a nonzero-destination write is presented.
  // Payload fields hold when idle; a $0 transfer still loads them and counts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      grf_a3    <= '0;
      grf_wd    <= '0;
      grf_pc    <= '0;
      grant_cnt <= '0;
      prio      <= 1'(INIT_PRIO);
    end else if (xfer) begin
      state     <= (win.a3 != 5'd0) ? WRITE : IDLE;
      grf_a3    <= win.a3;
      grf_wd    <= win.wd;
      grf_pc    <= win.pc;
      grant_cnt <= grant_cnt + 16'd1;
      if (contested) prio <= ~prio;
    end else begin
      state <= IDLE;
    end
  end

  assign grf_we = (state == WRITE);

  // Hazard mask for decode; $0 never reaches WRITE so bit 0 stays clear.
  always_comb begin
    pend_mask = grf_we ? (32'd1 << grf_a3) : 32'd0;
  end

endmodule
